cve2_mac_unit: RTL

Iterative multiply-accumulate execution unit. It is the responder side of the MAC sequencing interface: the MAC controller issues a request carrying operands, a multiplier operator and a signedness mode. The unit runs a multi-cycle shift-add multiply, then a single accumulate cycle, and returns a one-cycle `valid_o` pulse with the 32-bit result. It sits in the EX stage beside the ALU and multdiv; `mul_done_o` and `valid_o` drive the controller's `valid_ex_i` phase advance.

---
 rtl/cve2_pkg.sv | 19 +
 rtl/cve2_mac_unit_if.sv | 38 +++
 rtl/cve2_mac_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cve2_pkg.sv
// ============================================================================
// Module      : cve2_pkg
// Description : Shared types for the MAC execution unit and its controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cve2_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

endpackage

`default_nettype wire

// File: rtl/cve2_mac_unit_if.sv
// ============================================================================
// Module      : cve2_mac_unit_if
// Description : MAC sequencing interface between the MAC controller (master)
//               and the MAC execution unit (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cve2_mac_unit_if;
    import cve2_pkg::*;

    logic        req_i;
    logic        ready_o;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic [31:0] operand_c_i;
    md_op_e      md_operator_i;
    logic [1:0]  signed_mode_i;
    logic        kill_i;
    logic        mul_done_o;
    logic        valid_o;
    logic [31:0] result_o;

    modport master (
        output req_i, operand_a_i, operand_b_i, operand_c_i,
               md_operator_i, signed_mode_i, kill_i,
        input  ready_o, mul_done_o, valid_o, result_o
    );

    modport slave (
        input  req_i, operand_a_i, operand_b_i, operand_c_i,
               md_operator_i, signed_mode_i, kill_i,
        output ready_o, mul_done_o, valid_o, result_o
    );

endinterface

`default_nettype wire

// File: rtl/cve2_mac_unit.sv
// ============================================================================
// Module      : cve2_mac_unit
// Description : Iterative shift-add multiply followed by one accumulate cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cve2_mac_unit #(
    parameter int unsigned BitsPerCycle = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    cve2_mac_unit_if.slave    mac
);
    import cve2_pkg::*;

    localparam int unsigned NUM_CYCLES = 32 / BitsPerCycle;
    localparam logic [4:0]  LAST_CNT   = 5'(NUM_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2
    } state_e;

    state_e      state_q,    state_d;
    logic [4:0]  cnt_q,      cnt_d;
    logic [63:0] partial_q,  partial_d;
    logic [31:0] a_mag_q,    a_mag_d;
    logic [31:0] b_mag_q,    b_mag_d;
    logic        neg_q,      neg_d;
    logic [31:0] c_val_q,    c_val_d;
    md_op_e      op_q,       op_d;
    logic [31:0] result_q,   result_d;
    logic        valid_q,    valid_d;
    logic        mul_done_q, mul_done_d;

    logic                    accept;
    logic                    sign_a;
    logic                    sign_b;
    logic [BitsPerCycle-1:0] digit;
    logic [5:0]              shamt;
    logic [63:0]             pp;
    logic [63:0]             prod;
    logic [31:0]             word;

    assign accept = mac.req_i && (state_q == IDLE) && !mac.kill_i;
    assign sign_a = mac.signed_mode_i[0] & mac.operand_a_i[31];
    assign sign_b = mac.signed_mode_i[1] & mac.operand_b_i[31];

    // |b| is shifted right each MUL cycle so its low bits are always the next digit.
    assign digit  = b_mag_q[BitsPerCycle-1:0];
    assign shamt  = 6'(cnt_q) * 6'(BitsPerCycle);
    assign pp     = 64'(a_mag_q) * 64'(digit);
    assign prod   = neg_q ? (64'd0 - partial_q) : partial_q;

    always_comb begin
        word = 32'd0;
        case (op_q)
            MD_OP_MULL: word = prod[31:0];
            MD_OP_MULH: word = prod[63:32];
            default:    word = 32'd0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        partial_d  = partial_q;
        a_mag_d    = a_mag_q;
        b_mag_d    = b_mag_q;
        neg_d      = neg_q;
        c_val_d    = c_val_q;
        op_d       = op_q;
        result_d   = result_q;
        valid_d    = 1'b0;
        mul_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_mag_d   = sign_a ? (32'd0 - mac.operand_a_i) : mac.operand_a_i;
                    b_mag_d   = sign_b ? (32'd0 - mac.operand_b_i) : mac.operand_b_i;
                    neg_d     = sign_a ^ sign_b;
                    c_val_d   = mac.operand_c_i;
                    op_d      = mac.md_operator_i;
                    partial_d = 64'd0;
                    cnt_d     = 5'd0;
                    state_d   = MUL;
                end
            end
            MUL: begin
                partial_d = partial_q + (pp << shamt);
                b_mag_d   = b_mag_q >> BitsPerCycle;
                cnt_d     = cnt_q + 5'd1;
                if (cnt_q == LAST_CNT) begin
                    mul_done_d = 1'b1;
                    state_d    = ADD;
                end
            end
            ADD: begin
                result_d = c_val_q + word;
                valid_d  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A flush discards the operation without any completion side effects.
        if (mac.kill_i) begin
            state_d    = IDLE;
            valid_d    = 1'b0;
            mul_done_d = 1'b0;
            result_d   = result_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            partial_q  <= 64'd0;
            a_mag_q    <= 32'd0;
            b_mag_q    <= 32'd0;
            neg_q      <= 1'b0;
            c_val_q    <= 32'd0;
            op_q       <= MD_OP_MULL;
            result_q   <= 32'd0;
            valid_q    <= 1'b0;
            mul_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            partial_q  <= partial_d;
            a_mag_q    <= a_mag_d;
            b_mag_q    <= b_mag_d;
            neg_q      <= neg_d;
            c_val_q    <= c_val_d;
            op_q       <= op_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
            mul_done_q <= mul_done_d;
        end
    end

    assign mac.ready_o    = (state_q == IDLE);
    assign mac.valid_o    = valid_q;
    assign mac.mul_done_o = mul_done_q;
    assign mac.result_o   = result_q;

endmodule

`default_nettype wire
